// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-bus arbiter.
// Also holds the 2-bit arbiter state codes and the byte-enable width.
package bus_arbiter_pkg;

    localparam int BE_WIDTH = 4;
    localparam logic [BE_WIDTH-1:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_XFER = 2'd1,
        ARB_DM_XFER = 2'd2
    } arb_state_e;

    // Data side wins a tie unless the fetch side has been passed over too often.
    function automatic logic dm_wins(input logic dm_req, input logic if_req, input logic if_starved);
        return dm_req && !(if_req && if_starved);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/ack signal bundle between the pipeline requesters, the arbiter and the external bus.
// The slave modport is the arbiter's view; master is the surrounding pipeline/bus view.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                if_req_i;
    logic [ADDR_W-1:0]   if_addr_i;
    logic                if_rvalid_o;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                if_stall_o;

    logic                dm_req_i;
    logic                dm_we_i;
    logic [BE_WIDTH-1:0] dm_be_i;
    logic [ADDR_W-1:0]   dm_addr_i;
    logic [DATA_W-1:0]   dm_wdata_i;
    logic                dm_rvalid_o;
    logic [DATA_W-1:0]   dm_rdata_o;
    logic                dm_stall_o;

    logic                bus_req_o;
    logic                bus_we_o;
    logic [BE_WIDTH-1:0] bus_be_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_wdata_o;
    logic                bus_ack_i;
    logic [DATA_W-1:0]   bus_rdata_i;

    logic                err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rvalid_o, if_rdata_o, if_stall_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_rvalid_o, dm_rdata_o, dm_stall_o,
        output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rvalid_o, if_rdata_o, if_stall_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_rvalid_o, dm_rdata_o, dm_stall_o,
        input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/bus_arbiter_wait_counter.sv
// arb_wait_counter: counts cycles spent in a bus transfer and flags expiry at WAIT_MAX.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module arb_wait_counter
    import bus_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] wait_cnt;

    // Cleared whenever the arbiter is idle so each transfer starts from zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (!count_en) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(WAIT_MAX)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = count_en && (wait_cnt == CW'(WAIT_MAX));

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one unified bus between instruction fetch and load/store, one transfer at a time.
// Optional transfer timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_MAX     = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bus_arbiter_if.slave arb
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [BE_WIDTH-1:0] bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

    logic if_starved;
    logic timeout_expired;
    logic xfer_done;
    logic if_own;
    logic dm_own;

`ifdef BUS_TIMEOUT_EN
    arb_wait_counter #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .count_en (state_q != ARB_IDLE),
        .expired  (timeout_expired)
    );

    // A real ack in the expiry cycle wins; err only flags a genuine abort.
    assign arb.err_o = timeout_expired && !arb.bus_ack_i;
`else
    logic unused_wait_cfg;

    assign unused_wait_cfg = (WAIT_MAX != 0);
    assign timeout_expired = 1'b0;
    assign arb.err_o       = 1'b0;
`endif

    assign if_starved = (starve_q == SW'(STARVE_LIMIT));
    assign xfer_done  = arb.bus_ack_i || timeout_expired;
    assign if_own     = (state_q == ARB_IF_XFER);
    assign dm_own     = (state_q == ARB_DM_XFER);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Grants are only made from IDLE, so every transfer is followed by a one-cycle bubble.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (dm_wins(arb.dm_req_i, arb.if_req_i, if_starved)) begin
                    state_d     = ARB_DM_XFER;
                    bus_req_d   = 1'b1;
                    bus_we_d    = arb.dm_we_i;
                    bus_be_d    = arb.dm_be_i;
                    bus_addr_d  = arb.dm_addr_i;
                    bus_wdata_d = arb.dm_wdata_i;
                    if (!arb.if_req_i) begin
                        starve_d = '0;
                    end else if (!if_starved) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (arb.if_req_i) begin
                    state_d     = ARB_IF_XFER;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = BE_FULL;
                    bus_addr_d  = arb.if_addr_i;
                    bus_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            ARB_IF_XFER, ARB_DM_XFER: begin
                if (xfer_done) begin
                    state_d     = ARB_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign arb.bus_req_o   = bus_req_q;
    assign arb.bus_we_o    = bus_we_q;
    assign arb.bus_be_o    = bus_be_q;
    assign arb.bus_addr_o  = bus_addr_q;
    assign arb.bus_wdata_o = bus_wdata_q;

    // On a timeout abort the owner still sees rvalid, but with zeroed data.
    assign arb.if_rvalid_o = if_own && xfer_done;
    assign arb.if_rdata_o  = (if_own && arb.bus_ack_i) ? arb.bus_rdata_i : '0;
    assign arb.dm_rvalid_o = dm_own && xfer_done;
    assign arb.dm_rdata_o  = (dm_own && arb.bus_ack_i) ? arb.bus_rdata_i : '0;

    assign arb.if_stall_o  = arb.if_req_i && !arb.if_rvalid_o;
    assign arb.dm_stall_o  = arb.dm_req_i && !arb.dm_rvalid_o;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one unified instruction/data bus between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between pc_reg/rom and mem on one side and the external bus on the other.
- Serialises transfers with a one-outstanding request/ack protocol.
- Raises per-requester stall signals so the pipeline holds while its access is pending.

Parameters:
- ADDR_W, 32, address width; matches `ADDR_WIDTH.
- DATA_W, 32, data width; matches `DATA_WIDTH.
- STARVE_LIMIT, 4, consecutive data grants allowed while IF is waiting; must be >= 1.
- WAIT_MAX, 15, bus-wait cycles before abort; used only with BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rvalid_o  out  1  fetch complete, one-cycle pulse
- if_rdata_o  out  DATA_W  fetched word; valid with if_rvalid_o
- if_stall_o  out  1  if_req_i && !if_rvalid_o
- dm_req_i  in  1  data request; held with address/controls until dm_rvalid_o
- dm_we_i  in  1  1 = store
- dm_be_i  in  4  byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rvalid_o  out  1  data access complete, one-cycle pulse
- dm_rdata_o  out  DATA_W  load data; valid with dm_rvalid_o
- dm_stall_o  out  1  dm_req_i && !dm_rvalid_o
- bus_req_o  out  1  bus transfer active
- bus_we_o  out  1  bus write
- bus_be_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_ack_i  in  1  transfer done this cycle
- bus_rdata_i  in  DATA_W  read data; valid with bus_ack_i
- err_o  out  1  timeout pulse; constant 0 without BUS_TIMEOUT_EN

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE; starvation counter = 0; wait counter = 0.
  - All bus_* outputs = 0; err_o = 0.
- FSM states: IDLE, IF_XFER, DM_XFER.
- IDLE, choosing the next owner:
  - Only dm_req_i high -> DM_XFER.
  - Only if_req_i high -> IF_XFER.
  - Both high -> DM_XFER, unless starve_cnt == STARVE_LIMIT, then IF_XFER.
  - Neither high -> stay in IDLE.
- Grant registering:
  - On entry to a XFER state, bus_addr_o/we/be/wdata are registered from the winner; bus_req_o = 1.
  - IF transfers drive bus_we_o = 0 and bus_be_o = 4'hF.
  - Bus outputs stay stable until ack.
- starve_cnt:
  - Increments, saturating, on each DM grant made while if_req_i is high.
  - Clears on any IF grant, and on a DM grant made while if_req_i is low.
- XFER states:
  - Wait for bus_ack_i.
  - In the ack cycle, the owner's rvalid_o = 1 and rdata_o = bus_rdata_i (combinational passthrough).
  - Store acks also pulse dm_rvalid_o; dm_rdata_o is don't-care but driven to bus_rdata_i.
  - Next edge: bus_req_o = 0, state -> IDLE.
- Mandatory IDLE bubble: the requester updates its request on the same edge as the ack, so arbitration always uses fresh inputs.
- Latency:
  - Request at cycle N from IDLE -> bus_req_o at N+1.
  - Ack at M -> rvalid at M.
  - Next bus_req_o no earlier than M+2.
  - Minimum 3 cycles per transfer with zero-wait memory.
- rdata_o/rvalid_o of the non-owner are 0.
- stall outputs are purely combinational.
- Requester drops req while in XFER: protocol violation; the transfer completes anyway and the rvalid pulse is still issued.
- bus_ack_i while in IDLE: ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - wait_cnt counts cycles in XFER.
  - If wait_cnt reaches WAIT_MAX with no ack, the transfer aborts: owner rvalid pulses with rdata = 0, err_o pulses for 1 cycle, bus_req_o drops, state -> IDLE.
  - Ack in the same cycle as expiry counts as normal completion; err_o = 0.
- Undefined:
  - Waits indefinitely; no counter logic.
  - err_o tied to 0.

Decomposition:
- defines.v gains `ARB_IDLE, `ARB_IF_XFER, `ARB_DM_XFER (2-bit state codes) and `BE_WIDTH 4.
- One sub-module is natural: arb_wait_counter, the timeout counter, instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Reset mid-DM_XFER (rst_i low at any cycle) -> next sample: bus_req_o = 0, state IDLE, stalls follow the request inputs only.
- if_req_i = 1, addr 0x0000_0010; bus_ack_i one cycle after bus_req_o, rdata 0x0010_0093 -> bus_addr_o = 0x10 at N+1, if_rvalid_o and if_rdata_o = 0x0010_0093 at N+2, bus_req_o low at N+3.
- Simultaneous if_req_i / dm_req_i (load 0x100) -> DM granted first, dm_stall_o falls at ack, IF granted after the bubble.
- dm_req_i held continuously with if_req_i high, STARVE_LIMIT = 4 -> grants DM,DM,DM,DM,IF,DM...
- Store dm_we_i = 1, be = 4'b0011, addr 0x200, wdata 0xDEAD_BEEF -> bus_we_o = 1, bus_be_o = 3, bus_wdata_o = 0xDEAD_BEEF held until ack; dm_rvalid_o pulses.
- BUS_TIMEOUT_EN, WAIT_MAX = 15, no ack -> 15 cycles after bus_req_o, err_o and if_rvalid_o pulse with rdata 0, then IDLE. Repeat with ack on cycle 15 -> err_o stays 0.
